// File: rtl/instruction_fetch_pkg.sv
// Shared core package: fetch FSM state encoding, reset PC and canonical NOP.
// Also provides the word-alignment test applied to redirect targets.

package instruction_fetch_pkg;

    localparam int unsigned XLEN_DEFAULT     = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;  // addi x0, x0, 0

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2,
        FAULT = 2'd3
    } if_state_e;

    function automatic logic is_word_aligned(input logic [1:0] low_bits);
        return low_bits == 2'b00;
    endfunction

endpackage

// File: rtl/instruction_fetch.sv
// Single-outstanding instruction fetch unit: one request to imem at a time,
// one word held for decode, redirects drain any in-flight access first.

module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int unsigned     XLEN     = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
    input  logic            clk,
    input  logic            rst,

    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,

    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,

    output logic [31:0]     instruction,
    output logic [XLEN-1:0] out_pc_value,
    output logic            out_valid,
    input  logic            out_ready,

    output logic            fetch_fault
);

    if_state_e       state_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pending_pc_q;
    logic [31:0]     instruction_q;
    logic [XLEN-1:0] out_pc_value_q;
    logic            out_valid_q;
    logic            fetch_fault_q;

    // A redirect arriving with the draining ack supersedes the stored one.
    logic [XLEN-1:0] drain_target;
    assign drain_target = redirect_valid ? redirect_pc : pending_pc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= FETCH;
            pc_q           <= RESET_PC;
            pending_pc_q   <= '0;
            instruction_q  <= '0;
            out_pc_value_q <= '0;
            out_valid_q    <= 1'b0;
            fetch_fault_q  <= 1'b0;
        end else begin
            case (state_q)
                FETCH: begin
                    if (redirect_valid) begin
                        if (!imem_ack) begin
                            // The outstanding access must complete before the target is used.
                            pending_pc_q <= redirect_pc;
                            state_q      <= DRAIN;
                        end else if (!is_word_aligned(redirect_pc[1:0])) begin
                            fetch_fault_q <= 1'b1;
                            state_q       <= FAULT;
                        end else begin
                            pc_q <= redirect_pc;
                        end
                    end else if (imem_ack) begin
                        instruction_q  <= imem_rdata;
                        out_pc_value_q <= pc_q;
                        out_valid_q    <= 1'b1;
                        state_q        <= HOLD;
                    end
                end

                HOLD: begin
                    if (redirect_valid) begin
                        out_valid_q <= 1'b0;
                        if (!is_word_aligned(redirect_pc[1:0])) begin
                            fetch_fault_q <= 1'b1;
                            state_q       <= FAULT;
                        end else begin
                            pc_q    <= redirect_pc;
                            state_q <= FETCH;
                        end
                    end else if (out_ready) begin
                        pc_q        <= pc_q + XLEN'(4);
                        out_valid_q <= 1'b0;
                        state_q     <= FETCH;
                    end
                end

                DRAIN: begin
                    if (imem_ack) begin
                        if (!is_word_aligned(drain_target[1:0])) begin
                            fetch_fault_q <= 1'b1;
                            state_q       <= FAULT;
                        end else begin
                            pc_q    <= drain_target;
                            state_q <= FETCH;
                        end
                    end else if (redirect_valid) begin
                        pending_pc_q <= redirect_pc;
                    end
                end

                FAULT: begin
                    out_valid_q <= 1'b0;
                end

                default: begin
                    state_q <= FETCH;
                end
            endcase
        end
    end

    // NOTE: reset is synchronous, so the request is gated by rst directly to keep it low during reset.
    assign imem_req     = !rst && ((state_q == FETCH) || (state_q == DRAIN));
    assign imem_addr    = pc_q;
    assign instruction  = instruction_q;
    assign out_pc_value = out_pc_value_q;
    assign out_valid    = out_valid_q;
    assign fetch_fault  = fetch_fault_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed per-cycle vector table, then random
// memory latency / back-pressure / redirects against a next-PC stream model.

module tb_instruction_fetch;

    localparam int unsigned XLEN = 32;
    localparam logic [31:0] DB   = 32'hDEAD_BEEF;

    logic            clk = 1'b0;
    logic            rst;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [31:0]     imem_rdata;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic [31:0]     instruction;
    logic [XLEN-1:0] out_pc_value;
    logic            out_valid;
    logic            out_ready;
    logic            fetch_fault;

    always #5 clk = ~clk;

    instruction_fetch #(.XLEN(XLEN), .RESET_PC(32'h0)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instruction    (instruction),
        .out_pc_value   (out_pc_value),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .fetch_fault    (fetch_fault)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory contents: every word is a simple function of its address.
    function automatic logic [31:0] w(input logic [31:0] a);
        return 32'hC0DE_0000 ^ a;
    endfunction

    // One row = one clock cycle: inputs driven that cycle, outputs expected that cycle.
    typedef struct {
        logic [31:0] rst, ack, rdata, rv, rpc, ready;
        logic [31:0] e_req, e_addr, e_valid, e_instr, e_opc, e_fault, chk_data;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [31:0] r, ack, rdata, rv, rpc, ready,
                       input logic [31:0] e_req, e_addr, e_valid, e_instr, e_opc, e_fault, chk_data);
        vec_t v;
        v.rst = r; v.ack = ack; v.rdata = rdata; v.rv = rv; v.rpc = rpc; v.ready = ready;
        v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_instr = e_instr;
        v.e_opc = e_opc; v.e_fault = e_fault; v.chk_data = chk_data;
        tbl.push_back(v);
    endtask

    task automatic build_table();
        // Sequential fetch with immediate ack and ready: 0,4,8,12 at one word per 2 cycles.
        add(1, 0, 0,        0, 0, 0,   0, 0,    0, 0,    0,  0, 1);
        add(0, 1, w(0),     0, 0, 1,   1, 0,    0, 0,    0,  0, 1);
        add(0, 0, 0,        0, 0, 1,   0, 0,    1, w(0), 0,  0, 0);
        add(0, 1, w(4),     0, 0, 1,   1, 4,    0, w(0), 0,  0, 1);
        add(0, 0, 0,        0, 0, 1,   0, 0,    1, w(4), 4,  0, 0);
        add(0, 1, w(8),     0, 0, 1,   1, 8,    0, 0,    0,  0, 0);
        add(0, 0, 0,        0, 0, 1,   0, 0,    1, w(8), 8,  0, 0);
        add(0, 1, w(12),    0, 0, 1,   1, 12,   0, 0,    0,  0, 0);
        // Decode stalls five cycles in HOLD: word stable, no request.
        for (int i = 0; i < 5; i++)
            add(0, 0, 0,    0, 0, 0,   0, 0,    1, w(12), 12, 0, 0);
        add(0, 0, 0,        0, 0, 1,   0, 0,    1, w(12), 12, 0, 0);
        // Ack delayed three cycles: address stable, nothing valid.
        for (int i = 0; i < 3; i++)
            add(0, 0, 0,    0, 0, 0,   1, 16,   0, w(12), 12, 0, 1);
        add(0, 1, w(16),    0, 0, 0,   1, 16,   0, 0,    0,  0, 0);
        add(0, 0, 0,        0, 0, 1,   0, 0,    1, w(16), 16, 0, 0);
        // Redirect to 0x100 while the fetch of 0x14 is outstanding; its data is dropped.
        add(0, 0, 0,        1, 'h100, 0, 1, 'h14, 0, 0,  0,  0, 0);
        add(0, 0, 0,        0, 0, 0,   1, 'h14, 0, 0,    0,  0, 0);
        add(0, 1, DB,       0, 0, 1,   1, 'h14, 0, 0,    0,  0, 0);
        add(0, 1, w('h100), 0, 0, 0,   1, 'h100, 0, w(16), 16, 0, 1);
        add(0, 0, 0,        0, 0, 1,   0, 0,    1, w('h100), 'h100, 0, 0);
        // Redirect coinciding with ack in FETCH: data dropped, fetch restarts at 0x8.
        add(0, 1, DB,       1, 8, 0,   1, 'h104, 0, 0,   0,  0, 0);
        add(0, 1, w(8),     0, 0, 0,   1, 8,    0, w('h100), 'h100, 0, 1);
        // Redirect to 0x200 with out_ready in HOLD at pc 0x8: next fetch is 0x200, not 0xC.
        add(0, 0, 0,        1, 'h200, 1, 0, 0,  1, w(8), 8,  0, 0);
        add(0, 1, w('h200), 0, 0, 0,   1, 'h200, 0, w(8), 8, 0, 1);
        // Redirect without ready drops the held word.
        add(0, 0, 0,        1, 'h300, 0, 0, 0,  1, w('h200), 'h200, 0, 0);
        // Two redirects during a drain; the one on the ack cycle wins.
        add(0, 0, 0,        1, 'h400, 0, 1, 'h300, 0, 0, 0, 0, 0);
        add(0, 1, DB,       1, 'hFFFF_FFFC, 0, 1, 'h300, 0, 0, 0, 0, 0);
        add(0, 1, w('hFFFF_FFFC), 0, 0, 0, 1, 'hFFFF_FFFC, 0, w('h200), 'h200, 0, 1);
        // Top of address space wraps to 0.
        add(0, 0, 0,        0, 0, 1,   0, 0,    1, w('hFFFF_FFFC), 'hFFFF_FFFC, 0, 0);
        // Misaligned redirect during an outstanding fetch: fault only after the ack.
        add(0, 0, 0,        1, 'h102, 0, 1, 0,  0, 0,    0,  0, 0);
        add(0, 0, 0,        0, 0, 0,   1, 0,    0, 0,    0,  0, 0);
        add(0, 1, DB,       0, 0, 0,   1, 0,    0, 0,    0,  0, 0);
        add(0, 0, 0,        1, 'h500, 0, 0, 0,  0, 0,    0,  1, 0);
        add(0, 0, 0,        0, 0, 1,   0, 0,    0, 0,    0,  1, 0);
        // Reset clears the fault and fetch restarts at RESET_PC on the first cycle.
        add(1, 0, 0,        0, 0, 0,   0, 0,    0, 0,    0,  1, 0);
        add(0, 1, w(0),     0, 0, 0,   1, 0,    0, 0,    0,  0, 1);
        // Misaligned redirect in HOLD.
        add(0, 0, 0,        1, 7, 1,   0, 0,    1, w(0), 0,  0, 0);
        add(0, 0, 0,        0, 0, 0,   0, 0,    0, 0,    0,  1, 0);
        add(1, 0, 0,        0, 0, 0,   0, 0,    0, 0,    0,  1, 0);
        // Misaligned redirect coinciding with ack in FETCH.
        add(0, 1, DB,       1, 'h11, 0, 1, 0,   0, 0,    0,  0, 1);
        add(0, 0, 0,        0, 0, 0,   0, 0,    0, 0,    0,  1, 0);
        add(1, 0, 0,        0, 0, 0,   0, 0,    0, 0,    0,  1, 0);
    endtask

    task automatic run_table();
        foreach (tbl[i]) begin
            @(negedge clk);
            rst            = tbl[i].rst[0];
            imem_ack       = tbl[i].ack[0];
            imem_rdata     = tbl[i].rdata;
            redirect_valid = tbl[i].rv[0];
            redirect_pc    = tbl[i].rpc;
            out_ready      = tbl[i].ready[0];
            #1;
            check($sformatf("row%0d_req", i),   32'(imem_req),    tbl[i].e_req);
            check($sformatf("row%0d_valid", i), 32'(out_valid),   tbl[i].e_valid);
            check($sformatf("row%0d_fault", i), 32'(fetch_fault), tbl[i].e_fault);
            if (tbl[i].e_req[0])
                check($sformatf("row%0d_addr", i), imem_addr, tbl[i].e_addr);
            if (tbl[i].e_valid[0] || tbl[i].chk_data[0]) begin
                check($sformatf("row%0d_instr", i), instruction,  tbl[i].e_instr);
                check($sformatf("row%0d_pc", i),    out_pc_value, tbl[i].e_opc);
            end
        end
    endtask

    // Random phase. The model only knows the architectural rule: the next word
    // handed to decode belongs to the last redirect target, otherwise previous PC + 4.
    task automatic run_random(input int cycles);
        logic [31:0] exp_pc    = 32'h0;
        logic        prev_req  = 1'b0;
        logic        prev_ack  = 1'b0;
        logic [31:0] prev_addr = 32'h0;
        logic        prev_hold = 1'b0;
        int          wait_cnt  = 0;
        int          idle_cnt  = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            rst = 1'b0;
            #1;
            imem_ack       = imem_req && (($urandom_range(2) == 0) || (wait_cnt >= 3));
            imem_rdata     = imem_ack ? w(imem_addr) : $urandom;
            redirect_valid = ($urandom_range(7) == 0);
            redirect_pc    = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC))
                                                      : ($urandom & 32'hFFFF_FFFC);
            out_ready      = $urandom_range(1) == 1;
            #1;
            if (prev_req && !prev_ack) begin
                check("rnd_req_held", 32'(imem_req), 32'd1);
                check("rnd_addr_stable", imem_addr, prev_addr);
            end
            if (prev_hold)
                check("rnd_valid_held", 32'(out_valid), 32'd1);
            if (out_valid) begin
                check("rnd_pc", out_pc_value, exp_pc);
                check("rnd_instr", instruction, w(exp_pc));
            end
            check("rnd_fault", 32'(fetch_fault), 32'd0);

            wait_cnt  = (imem_req && !imem_ack) ? wait_cnt + 1 : 0;
            prev_req  = imem_req;
            prev_ack  = imem_ack;
            prev_addr = imem_addr;
            prev_hold = out_valid && !out_ready && !redirect_valid;
            if (out_valid && out_ready) begin
                exp_pc   = exp_pc + 32'd4;
                idle_cnt = 0;
            end else begin
                idle_cnt++;
            end
            if (redirect_valid)
                exp_pc = redirect_pc;
            if (idle_cnt > 200) begin
                check("rnd_liveness_idle_cycles", 32'(idle_cnt), 32'd0);
                idle_cnt = 0;
            end
        end
    endtask

    initial begin
        rst            = 1'b1;
        imem_ack       = 1'b0;
        imem_rdata     = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b0;
        repeat (2) @(posedge clk);

        build_table();
        run_table();
        run_random(3000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
